// File: rtl/intr_pkg.sv
// Shared constants and the fixed-priority picker for the interrupt receiver.
package intr_pkg;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_CLAIM   = 2'd2;

  localparam logic [3:0] ID_NONE = 4'd0;

  // Lowest set index wins; returns index+1, or ID_NONE when nothing is eligible.
  function automatic logic [3:0] prio_pick(input logic [7:0] elig);
    logic [3:0] id;
    id = ID_NONE;
    for (int i = 7; i >= 0; i--) begin
      if (elig[i]) id = 4'(i + 1);
    end
    return id;
  endfunction

endpackage

// File: rtl/intr_edge_detect.sv
// Per-source rising-edge detector; INTR_SYNC_EN inserts a 2-flop synchronizer
// ahead of the edge detect for asynchronous sources.
module intr_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic rise
);

  logic seen;
  logic prev;

`ifdef INTR_SYNC_EN
  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= irq;
      sync_p1 <= sync_p0;
    end
  end

  assign seen = sync_p1;
`else
  assign seen = irq;
`endif

  always_ff @(posedge clk) begin
    if (!rst) prev <= 1'b0;
    else      prev <= seen;
  end

  assign rise = seen & ~prev;

endmodule

// File: rtl/interrupt_receiver.sv
// Edge-triggered interrupt receiver with enable mask, fixed priority and an
// MMIO claim/complete window. Optional macro: INTR_SYNC_EN (input synchronizer).
module interrupt_receiver
  import intr_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int ID_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               reg_we,
  input  logic               reg_re,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               reg_rvalid,
  output logic               irq_req
);

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] clr_mask;
  logic [ID_W-1:0]    in_service;
  logic [ID_W-1:0]    pick_id;
  logic               svc_busy;
  logic               claim;
  logic               complete;
  logic [31:0]        rdata_nxt;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_edge
    intr_edge_detect u_edge (
      .clk  (clk),
      .rst  (rst),
      .irq  (irq_in[i]),
      .rise (rise[i])
    );
  end

  always_comb begin
    elig     = pending & enable;
    svc_busy = (in_service != '0);
    pick_id  = ID_W'(prio_pick(8'(elig)));
    claim    = reg_re && (reg_addr == ADDR_CLAIM) && !svc_busy && (|elig);
    complete = reg_we && (reg_addr == ADDR_CLAIM) && svc_busy &&
               (reg_wdata[ID_W-1:0] == in_service);

    clr_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (claim && (pick_id == ID_W'(i + 1))) clr_mask[i] = 1'b1;
    end

    // Reads always see pre-write state, including a same-cycle ENABLE write.
    rdata_nxt = '0;
    case (reg_addr)
      ADDR_ENABLE:  rdata_nxt = 32'(enable);
      ADDR_PENDING: rdata_nxt = 32'(pending);
      ADDR_CLAIM:   if (claim) rdata_nxt = 32'(pick_id);
      default:      rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending    <= '0;
      enable     <= '0;
      in_service <= '0;
      irq_req    <= 1'b0;
      reg_rvalid <= 1'b0;
      reg_rdata  <= '0;
    end else begin
      // A fresh rise on the claimed source survives the clear.
      pending <= (pending & ~clr_mask) | rise;
      if (reg_we && (reg_addr == ADDR_ENABLE)) enable <= reg_wdata[NUM_SRC-1:0];
      if (claim)         in_service <= pick_id;
      else if (complete) in_service <= '0;
      // Suppressed in the claim cycle so the request drops right after the claim.
      irq_req    <= (|elig) && !svc_busy && !claim;
      reg_rvalid <= reg_re;
      if (reg_re) reg_rdata <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_interrupt_receiver.sv
// Scoreboard bench for interrupt_receiver: directed scenarios followed by
// randomized traffic, checked against a cycle-level behavioural model.
module tb_interrupt_receiver;

  localparam int N = 2;
`ifdef INTR_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] irq_in = '0;
  logic         reg_we = 1'b0;
  logic         reg_re = 1'b0;
  logic [1:0]   reg_addr = '0;
  logic [31:0]  reg_wdata = '0;
  logic [31:0]  reg_rdata;
  logic         reg_rvalid;
  logic         irq_req;

  interrupt_receiver #(.NUM_SRC(N), .ID_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .reg_rvalid (reg_rvalid),
    .irq_req    (irq_req)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Reference model state: plain bit arrays and an integer in-service ID.
  bit        m_en   [N];
  bit        m_pend [N];
  bit        m_prev [N];
  bit        m_s1   [N];
  bit        m_s2   [N];
  int        m_svc;
  bit        exp_irq;
  bit        armed = 1'b0;
  int        exp_q[$];

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        for (int i = 0; i < N; i++) begin
          m_en[i] = 0; m_pend[i] = 0; m_prev[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
        end
        m_svc = 0;
        exp_irq = 0;
        exp_q.delete();
        armed = 1'b1;
      end else begin
        bit seen [N];
        int cand;
        bit take;
        int rsp;
        for (int i = 0; i < N; i++) begin
`ifdef INTR_SYNC_EN
          seen[i] = m_s2[i];
          m_s2[i] = m_s1[i];
          m_s1[i] = irq_in[i];
`else
          seen[i] = irq_in[i];
`endif
        end
        cand = -1;
        if (m_svc == 0)
          for (int i = N - 1; i >= 0; i--)
            if (m_pend[i] && m_en[i]) cand = i;
        take = reg_re && (reg_addr == 2'd2) && (cand >= 0);
        if (reg_re) begin
          rsp = 0;
          for (int i = 0; i < N; i++) begin
            if (reg_addr == 2'd0 && m_en[i])   rsp += (1 << i);
            if (reg_addr == 2'd1 && m_pend[i]) rsp += (1 << i);
          end
          if (reg_addr == 2'd2) rsp = take ? cand + 1 : 0;
          exp_q.push_back(rsp);
        end
        exp_irq = (cand >= 0) && !take;
        if (take) begin
          m_pend[cand] = 0;
          m_svc = cand + 1;
        end else if (reg_we && reg_addr == 2'd2 && m_svc != 0 && int'(reg_wdata[3:0]) == m_svc) begin
          m_svc = 0;
        end
        for (int i = 0; i < N; i++) begin
          if (seen[i] && !m_prev[i]) m_pend[i] = 1;
          m_prev[i] = seen[i];
        end
        if (reg_we && reg_addr == 2'd0)
          for (int i = 0; i < N; i++) m_en[i] = reg_wdata[i];
      end
    end
  end

  // Monitor: compares every cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("irq_req", {31'd0, irq_req}, {31'd0, exp_irq});
        chk("rvalid", {31'd0, reg_rvalid}, {31'd0, exp_q.size() != 0});
        if (reg_rvalid && exp_q.size() != 0) chk("rdata", reg_rdata, exp_q.pop_front());
        else if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  task automatic op(input logic we, input logic re, input logic [1:0] a, input logic [31:0] d);
    reg_we = we; reg_re = re; reg_addr = a; reg_wdata = d;
    @(negedge clk);
    reg_we = 1'b0; reg_re = 1'b0; reg_wdata = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    chk("reset_rdata", reg_rdata, 32'd0);
    chk("reset_irq", {31'd0, irq_req}, 32'd0);

    // Single pulse on source 0: request appears LAT cycles later.
    op(1, 0, 2'd0, 32'h1);
    irq_in = 2'b01;
    idle(LAT - 1);
    chk("lat_before", {31'd0, irq_req}, 32'd0);
    irq_in = 2'b00;
    idle(1);
    chk("lat_at", {31'd0, irq_req}, 32'd1);
    op(0, 1, 2'd2, 0);
    idle(1);
    chk("drop_after_claim", {31'd0, irq_req}, 32'd0);
    op(1, 0, 2'd2, 32'h1);
    idle(3);
    chk("stay_low", {31'd0, irq_req}, 32'd0);

    // Both sources together: priority, no nesting, then the second one.
    op(1, 0, 2'd0, 32'h3);
    irq_in = 2'b11; idle(1); irq_in = 2'b00;
    idle(LAT + 1);
    op(0, 1, 2'd2, 0);
    op(0, 1, 2'd2, 0);
    op(1, 0, 2'd2, 32'h1);
    idle(2);
    chk("reassert", {31'd0, irq_req}, 32'd1);
    op(0, 1, 2'd2, 0);
    op(1, 0, 2'd2, 32'h2);

    // Masked source keeps its pending bit.
    op(1, 0, 2'd0, 32'h0);
    irq_in = 2'b10; idle(1); irq_in = 2'b00;
    idle(LAT + 1);
    op(0, 1, 2'd1, 0);
    idle(2);
    op(1, 0, 2'd0, 32'h2);
    idle(2);
    chk("unmask_irq", {31'd0, irq_req}, 32'd1);
    op(0, 1, 2'd2, 0);
    op(1, 0, 2'd2, 32'h2);

    // Held level gives one event only.
    op(1, 0, 2'd0, 32'h1);
    irq_in = 2'b01;
    idle(LAT + 2);
    op(0, 1, 2'd2, 0);
    op(1, 0, 2'd2, 32'h1);
    idle(16);
    chk("held_level", {31'd0, irq_req}, 32'd0);
    irq_in = 2'b00;
    idle(2);

    // Wrong complete ID ignored, then reset mid-service.
    irq_in = 2'b01; idle(1); irq_in = 2'b00;
    idle(LAT + 1);
    op(0, 1, 2'd2, 0);
    op(1, 0, 2'd2, 32'h2);
    op(0, 1, 2'd2, 0);
    op(1, 1, 2'd3, 32'hffff);
    rst = 1'b0;
    reg_re = 1'b1; reg_addr = 2'd1;
    idle(1);
    reg_re = 1'b0;
    rst = 1'b1;
    chk("midrst_rdata", reg_rdata, 32'd0);
    chk("midrst_rvalid", {31'd0, reg_rvalid}, 32'd0);
    op(0, 1, 2'd0, 0);
    op(0, 1, 2'd1, 0);
    op(0, 1, 2'd2, 0);
    idle(2);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      int k;
      if ($urandom_range(0, 7) == 0) irq_in = irq_in ^ 2'b01;
      if ($urandom_range(0, 7) == 0) irq_in = irq_in ^ 2'b10;
      rst = ($urandom_range(0, 299) != 0);
      k = $urandom_range(0, 9);
      reg_we = 1'b0; reg_re = 1'b0; reg_wdata = '0;
      reg_addr = 2'($urandom_range(0, 3));
      case (k)
        0, 1: reg_re = 1'b1;
        2, 3: begin reg_re = 1'b1; reg_addr = 2'd2; end
        4: begin reg_we = 1'b1; reg_addr = 2'd0; reg_wdata = 32'($urandom_range(0, 3)); end
        5, 6: begin reg_we = 1'b1; reg_addr = 2'd2; reg_wdata = 32'($urandom_range(0, 3)); end
        7: begin reg_we = 1'b1; reg_re = 1'b1; reg_wdata = $urandom; end
        default: ;
      endcase
      idle(1);
    end
    reg_we = 1'b0; reg_re = 1'b0; rst = 1'b1;
    idle(3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/interrupt_receiver.md
Name: interrupt_receiver

Overview:
- CPU-side consumer of the single-bit interrupt lines driven by accelerator interrupt registers (CNN done, DMA done, ...).
- Detects rising edges, latches per-source pending bits, applies an enable mask and fixed priority, and raises one request line to the CPU.
- CPU services interrupts through a small memory-mapped claim/complete register window.
- Sits between the accelerator interrupt outputs and the CPU external-interrupt input.

Parameters:
- NUM_SRC, 2, number of interrupt sources (1..8); source 0 has the highest priority.
- ID_W, 4, width of claim/complete ID field; ID = source index + 1, and 0 means none.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
- irq_in  input  NUM_SRC  level interrupt lines from the source interrupt registers.
- reg_we  input  1  MMIO write strobe, one cycle per access.
- reg_re  input  1  MMIO read strobe, one cycle per access.
- reg_addr  input  2  word select: 0=ENABLE (RW), 1=PENDING (RO), 2=CLAIM/COMPLETE, 3=reserved.
- reg_wdata  input  32  write data.
- reg_rdata  output  32  read data; valid in the cycle after reg_re.
- reg_rvalid  output  1  one-cycle pulse accompanying reg_rdata.
- irq_req  output  1  interrupt request to the CPU.

Behaviour:
- Reset (rst==0 at clk edge): enable=0, pending=0, in_service=0, irq_prev=0, reg_rdata=0, reg_rvalid=0, irq_req=0. Reset applies mid-transaction and discards any read in flight.
- Edge detect: irq_prev<=irq_in each cycle. rise[i]=irq_in[i]&~irq_prev[i]. A rise sets pending[i] on the next edge. A level held high produces exactly one event.
- irq_req is registered: irq_req <= |(pending & enable) & ~in_service_any. At most one interrupt is in service at a time, so there is no nesting.
- Latency: irq_in rising in cycle N -> pending in N+1 -> irq_req in N+2.
- ENABLE write: enable <= reg_wdata[NUM_SRC-1:0]. Disabling a source masks it but keeps its pending bit.
- PENDING read returns {0, pending}. Writes to it are ignored.
- CLAIM read:
  - Selects the lowest index i with pending[i]&enable[i].
  - Returns i+1 in reg_rdata[ID_W-1:0], clears pending[i], sets in_service=i+1.
  - If nothing is eligible, or a source is already in service: returns 0 and changes no state.
- COMPLETE (write to addr 2): if reg_wdata[ID_W-1:0]==in_service, in_service<=0. A mismatched or zero ID is ignored.
- Reads of addr 3 return 0; writes to addr 3 are ignored.
- Simultaneous events:
  - A rise on source i in the same cycle as a claim of i: pending[i] ends up 1 (the new event is kept).
  - reg_we and reg_re asserted together: both are performed; the read returns pre-write state.
  - ENABLE write in the same cycle as a claim: the claim uses the old enable.
- irq_req drops no later than the cycle after the claim read is accepted. It may re-assert 1 cycle after complete if other eligible pending bits remain.

Optional Feature:
- INTR_SYNC_EN
  - Defined: irq_in passes through a 2-flop synchronizer before edge detection (for asynchronous sources). Synchronizer flops reset to 0. End-to-end latency becomes N+4.
  - Undefined: irq_in is used directly, with latency as stated above.

Decomposition:
- Package intr_pkg holds:
  - address constants ADDR_ENABLE=2'd0, ADDR_PENDING=2'd1, ADDR_CLAIM=2'd2;
  - ID_NONE=0;
  - a function prio_pick(pending&enable) returning the ID.
- Natural sub-module: intr_edge_detect. It is per-source, holds the optional synchronizer plus the prev flop, and outputs the rise pulse.
- The top module holds the pending, enable and in_service state, the MMIO decode and irq_req.

Test Plan:
- Reset then ENABLE=2'b01; pulse irq_in[0] high for 1 cycle -> irq_req=1 two cycles later; CLAIM read returns 1 with reg_rvalid, irq_req drops; COMPLETE 1 -> in_service=0, irq_req stays 0.
- ENABLE=2'b11; irq_in=2'b11 in the same cycle -> CLAIM returns 1. A second CLAIM before complete returns 0. After COMPLETE 1, irq_req re-asserts and CLAIM returns 2.
- ENABLE=0; irq_in[1] rises -> PENDING reads 2'b10 and irq_req stays 0. Then write ENABLE=2'b10 -> irq_req=1 within 2 cycles.
- irq_in[0] held high for 20 cycles -> exactly one pending event; after claim/complete, irq_req remains 0.
- In_service=1: COMPLETE with 2 -> ignored, in_service still 1. Drive rst=0 for 1 cycle mid-service -> every output and register is 0 afterwards.
- INTR_SYNC_EN defined: irq_in[0] rise at cycle N -> irq_req asserted at N+4. With the macro undefined, the same stimulus gives N+2.
